// File: rtl/fft_job_ctrl_if.sv
// Request/response channels between the FFT job controller, the host interface
// and the AFU FIFO strobes.
interface fft_job_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  in_fifo_pop;
  logic                  out_fifo_empty;
  logic                  out_fifo_re;
  logic                  wr_almost_full;
  logic                  wr_req_valid;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic                  wr_ack;

  modport master (
    output rd_req_valid, rd_req_addr, out_fifo_re, wr_req_valid, wr_req_addr,
    input  rd_req_ready, in_fifo_pop, out_fifo_empty, wr_almost_full, wr_ack
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, out_fifo_re, wr_req_valid, wr_req_addr,
    output rd_req_ready, in_fifo_pop, out_fifo_empty, wr_almost_full, wr_ack
  );
endinterface

// File: rtl/fft_job_ctrl.sv
// Job sequencer for the streaming FFT AFU: credit-limited line reads, output FIFO
// drain into line writes, and write-ack counting up to job completion.
module fft_job_ctrl #(
  parameter int BUFF_DEPTH_BITS = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  ctx_length,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  output logic                  busy,
  output logic                  done,
  fft_job_ctrl_if.master        bus,
  output logic [LEN_WIDTH-1:0]  rd_count,
  output logic [LEN_WIDTH-1:0]  wr_count
);

  localparam int                CRED_W   = BUFF_DEPTH_BITS + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(2 ** BUFF_DEPTH_BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [LEN_WIDTH-1:0]  length_q;
  logic [LEN_WIDTH-1:0]  pop_count;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [CRED_W-1:0]     credits;
  logic                  start_acc;
  logic                  rd_fire;
  logic                  wr_vld_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;

  assign start_acc = start && (state != RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  assign bus.rd_req_valid = busy && (rd_count < length_q) && (credits != '0);
  assign bus.rd_req_addr  = src_q + ADDR_WIDTH'(rd_count);
  assign rd_fire          = bus.rd_req_valid && bus.rd_req_ready;
  assign bus.out_fifo_re  = busy && !bus.out_fifo_empty && !bus.wr_almost_full &&
                            (pop_count < length_q);
  assign bus.wr_req_valid = wr_vld_p1;
  assign bus.wr_req_addr  = wr_addr_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (ctx_length != '0) ? RUN : DONE;
      RUN:        if (wr_count >= length_q) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Job context and progress counters; a start outranks any same-cycle ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      length_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      pop_count <= '0;
    end else if (start_acc) begin
      length_q  <= ctx_length;
      src_q     <= src_base;
      dst_q     <= dst_base;
      rd_count  <= '0;
      wr_count  <= '0;
      pop_count <= '0;
    end else begin
      if (rd_fire)                          rd_count  <= rd_count + LEN_WIDTH'(1);
      if (bus.wr_ack && (state != IDLE))    wr_count  <= wr_count + LEN_WIDTH'(1);
      if (bus.out_fifo_re)                  pop_count <= pop_count + LEN_WIDTH'(1);
    end
  end

  // Credits mirror free slots in the AFU input FIFO; surplus pops are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CRED_MAX;
    end else if (rd_fire && !bus.in_fifo_pop) begin
      credits <= credits - CRED_W'(1);
    end else if (!rd_fire && bus.in_fifo_pop && (credits != CRED_MAX)) begin
      credits <= credits + CRED_W'(1);
    end
  end

  // Stage p1: write issued the cycle after the output FIFO pop; the pop count
  // before increment is the write index of that line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
    end else begin
      wr_vld_p1 <= bus.out_fifo_re;
      if (bus.out_fifo_re) wr_addr_p1 <= dst_q + ADDR_WIDTH'(pop_count);
    end
  end

endmodule

// File: tb/tb_fft_job_ctrl.sv
// Randomized bench for fft_job_ctrl: AFU/host environment model, job-level reference
// model and address scoreboards checked by an independent monitor.
module tb_fft_job_ctrl;

  localparam int CRED_MAX = 8;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] ctx_length, src_base, dst_base;
  logic        busy, done;
  logic [31:0] rd_count, wr_count;

  fft_job_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  fft_job_ctrl #(.BUFF_DEPTH_BITS(3), .ADDR_WIDTH(32), .LEN_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ctx_length(ctx_length),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
    .bus(bus), .rd_count(rd_count), .wr_count(wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Environment knobs, set by the stimulus process
  int rdy_pct = 100, pop_pct = 100, af_mode = 0;
  bit pop_once = 0, extra_pop = 0, force_ack = 0, stray_en = 0;

  // Environment: host read responses feed the AFU input FIFO, the AFU moves lines to
  // its output FIFO after two cycles, and the host acks writes after 1..4 cycles.
  int in_q = 0, out_q = 0, cyc = 0;
  int pipe_q[$];
  int ack_q[$];
  bit ev_hs = 0, ev_re = 0, ev_wr = 0, af_tgl = 0;

  initial begin
    bus.rd_req_ready = 1'b0; bus.in_fifo_pop = 1'b0; bus.out_fifo_empty = 1'b1;
    bus.wr_almost_full = 1'b0; bus.wr_ack = 1'b0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (ev_hs) in_q++;
      if (ev_re) out_q--;
      if (ev_wr) ack_q.push_back(cyc + int'($urandom_range(1, 4)));
      while (pipe_q.size() > 0 && pipe_q[0] <= cyc) begin
        void'(pipe_q.pop_front());
        out_q++;
      end
      bus.in_fifo_pop = 1'b0;
      if (in_q > 0 && (pop_once || $urandom_range(0, 99) < pop_pct)) begin
        bus.in_fifo_pop = 1'b1;
        in_q--;
        pipe_q.push_back(cyc + 2);
        pop_once = 0;
      end
      if (extra_pop) begin
        bus.in_fifo_pop = 1'b1;
        extra_pop = 0;
      end
      bus.rd_req_ready = ($urandom_range(0, 99) < rdy_pct);
      af_tgl = !af_tgl;
      case (af_mode)
        0:       bus.wr_almost_full = 1'b0;
        1:       bus.wr_almost_full = ($urandom_range(0, 2) == 0);
        default: bus.wr_almost_full = af_tgl;
      endcase
      bus.out_fifo_empty = (out_q == 0);
      bus.wr_ack = 1'b0;
      for (int i = 0; i < ack_q.size(); i++) begin
        if (ack_q[i] <= cyc) begin
          bus.wr_ack = 1'b1;
          ack_q.delete(i);
          break;
        end
      end
      if (force_ack) begin
        bus.wr_ack = 1'b1;
        force_ack = 0;
      end
      #1;
      if (!reset) begin
        in_q = 0; out_q = 0; pipe_q.delete(); ack_q.delete();
        ev_hs = 0; ev_re = 0; ev_wr = 0;
      end else begin
        ev_hs = bus.rd_req_valid && bus.rd_req_ready;
        ev_re = bus.out_fifo_re;
        ev_wr = bus.wr_req_valid;
      end
    end
  end

  // Reference model and scoreboards
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wr[$];
  int          m_st = ST_IDLE, m_cred = CRED_MAX;
  logic [31:0] m_len = 0, m_rd = 0, m_wr = 0, m_pops = 0, m_prev_addr = 0;
  bit          m_prev_re = 0, m_prev_vld = 0, m_prev_rdy = 0;

  initial begin
    bit          exp_vld, exp_re, hs_m;
    int          st_old;
    logic [31:0] e;
    forever begin
      @(negedge clk); #3;
      if (!reset) begin
        chk("reset_ctrl", {busy, done, bus.rd_req_valid, bus.wr_req_valid, bus.out_fifo_re}, 0);
        chk("reset_counts", {rd_count, wr_count}, 0);
        chk("reset_addrs", {bus.rd_req_addr, bus.wr_req_addr}, 0);
        m_st = ST_IDLE; m_cred = CRED_MAX; m_len = 0; m_rd = 0; m_wr = 0; m_pops = 0;
        m_prev_re = 0; m_prev_vld = 0; m_prev_rdy = 0;
        exp_rd.delete(); exp_wr.delete();
        continue;
      end
      exp_vld = (m_st == ST_RUN) && (m_rd < m_len) && (m_cred != 0);
      exp_re  = (m_st == ST_RUN) && !bus.out_fifo_empty && !bus.wr_almost_full && (m_pops < m_len);
      chk("busy", busy, m_st == ST_RUN);
      chk("done", done, m_st == ST_DONE);
      chk("rd_count", rd_count, m_rd);
      chk("wr_count", wr_count, m_wr);
      chk("rd_req_valid", bus.rd_req_valid, exp_vld);
      chk("out_fifo_re", bus.out_fifo_re, exp_re);
      chk("wr_req_valid", bus.wr_req_valid, m_prev_re);
      if (m_prev_vld && !m_prev_rdy && bus.rd_req_valid)
        chk("rd_addr_hold", bus.rd_req_addr, m_prev_addr);
      if (bus.rd_req_valid && bus.rd_req_ready) begin
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hDEAD_BEEF;
        chk("rd_req_addr", bus.rd_req_addr, e);
      end
      if (bus.wr_req_valid) begin
        e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 32'hDEAD_BEEF;
        chk("wr_req_addr", bus.wr_req_addr, e);
      end
      hs_m   = exp_vld && bus.rd_req_ready;
      st_old = m_st;
      if (m_st != ST_RUN && start) begin
        m_len = ctx_length; m_rd = 0; m_wr = 0; m_pops = 0;
        m_st  = (ctx_length != 0) ? ST_RUN : ST_DONE;
        exp_rd.delete(); exp_wr.delete();
        for (int unsigned i = 0; i < m_len; i++) begin
          exp_rd.push_back(src_base + i);
          exp_wr.push_back(dst_base + i);
        end
      end else begin
        if (m_st == ST_RUN && m_wr >= m_len) m_st = ST_DONE;
        if (hs_m) m_rd++;
        if (bus.wr_ack && st_old != ST_IDLE) m_wr++;
        if (exp_re) m_pops++;
      end
      if (hs_m && !bus.in_fifo_pop) m_cred--;
      else if (!hs_m && bus.in_fifo_pop && m_cred < CRED_MAX) m_cred++;
      m_prev_re   = exp_re;
      m_prev_vld  = bus.rd_req_valid;
      m_prev_rdy  = bus.rd_req_ready;
      m_prev_addr = bus.rd_req_addr;
    end
  end

  // Stimulus
  logic [31:0] cur_len;

  task automatic start_job(input logic [31:0] len, input logic [31:0] s, input logic [31:0] d,
                           input bit with_ack);
    @(negedge clk);
    start = 1'b1; ctx_length = len; src_base = s; dst_base = d; cur_len = len;
    if (with_ack) force_ack = 1;
    @(negedge clk);
    start = 1'b0; ctx_length = $urandom_range(1, 50); src_base = $urandom; dst_base = $urandom;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (stray_en && busy && (wr_count + 2 < cur_len) && $urandom_range(0, 15) == 0) begin
        start = 1'b1; ctx_length = $urandom_range(1, 50); src_base = $urandom; dst_base = $urandom;
      end
    end
    start = 1'b0;
    chk("done_reached", done, 1'b1);
  endtask

  task automatic run_job(input logic [31:0] len, input logic [31:0] s, input logic [31:0] d,
                         input int max_cyc);
    start_job(len, s, d, 0);
    wait_done(max_cyc);
    chk("job_rd_count", rd_count, len);
    chk("job_wr_count", wr_count, len);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; ctx_length = 0; src_base = 0; dst_base = 0; cur_len = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single line with immediate loopback
    run_job(1, 32'h0000_1000, 32'h0000_8000, 200);

    // A pop with the credit pool already full must be ignored
    extra_pop = 1;
    repeat (3) @(negedge clk);

    // Credit limit, then a held request while not ready, then one returned credit
    rdy_pct = 0; pop_pct = 0;
    start_job(20, 32'h0002_0000, 32'h0003_0000, 0);
    repeat (5) @(negedge clk);
    chk("hold_rd_count", rd_count, 0);
    chk("hold_rd_valid", bus.rd_req_valid, 1'b1);
    rdy_pct = 100;
    repeat (20) @(negedge clk);
    chk("credit_cap_reads", rd_count, 8);
    chk("credit_cap_valid", bus.rd_req_valid, 1'b0);
    pop_once = 1;
    repeat (10) @(negedge clk);
    chk("one_credit_one_read", rd_count, 9);
    pop_pct = 60;
    wait_done(2000);
    chk("len20_rd_count", rd_count, 20);
    chk("len20_wr_count", wr_count, 20);

    // Almost-full toggling every cycle
    rdy_pct = 100; pop_pct = 100; af_mode = 2;
    run_job(10, 32'h0004_0000, 32'h0005_0000, 1000);
    af_mode = 0;

    // Zero-length job
    start_job(0, 32'h0006_0000, 32'h0007_0000, 0);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("len0_no_reads", rd_count, 0);

    // Stale ack in DONE counts; start together with an ack clears the count
    force_ack = 1;
    @(negedge clk);
    chk("stale_ack_counted", wr_count, 1);
    start_job(2, 32'h0008_0000, 32'h0009_0000, 1);
    chk("start_beats_ack", wr_count, 0);
    wait_done(500);
    chk("after_ack_wr_count", wr_count, 2);

    // Reset in the middle of a 12-line job, then a clean 3-line job
    pop_pct = 80;
    start_job(12, 32'h000A_0000, 32'h000B_0000, 0);
    n = 0;
    while (wr_count < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_job_reached", wr_count >= 4, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_ctrl", {busy, done, bus.rd_req_valid, bus.wr_req_valid, bus.out_fifo_re}, 0);
    chk("abort_counts", {rd_count, wr_count}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_job(3, 32'h000C_0000, 32'h000D_0000, 500);

    // Randomized jobs with backpressure, address wrap and ignored starts while running
    for (int j = 0; j < 10; j++) begin
      logic [31:0] l, s, d;
      rdy_pct = $urandom_range(30, 100);
      pop_pct = $urandom_range(20, 100);
      af_mode = $urandom_range(0, 2);
      stray_en = 1;
      l = $urandom_range(1, 40);
      s = (j == 3) ? 32'hFFFF_FFF0 : $urandom;
      d = (j == 5) ? 32'hFFFF_FFFA : $urandom;
      run_job(l, s, d, 4000);
    end
    stray_en = 0;

    repeat (5) @(negedge clk);
    chk("rd_scoreboard_empty", exp_rd.size(), 0);
    chk("wr_scoreboard_empty", exp_wr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_job_ctrl.md
Name: fft_job_ctrl

Overview:
- Job sequencer for the streaming 4x4 FFT AFU datapath.
- On a start command it issues ctx_length cache-line read requests, limited by credits so the AFU input FIFO can never overflow.
- It drains the AFU output FIFO into cache-line write requests and counts write acknowledgements.
- It reports done when every line has been written back.
- It sits between the host-interface request/response channels and the AFU FIFO ports.

Parameters:
- BUFF_DEPTH_BITS, 3: log2 depth of the AFU input FIFO. Initial read credit = 2**BUFF_DEPTH_BITS.
- ADDR_WIDTH, 32: cache-line address width.
- LEN_WIDTH, 32: job length counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start pulse
- ctx_length  in  LEN_WIDTH  job length in cache lines, sampled on accepted start
- src_base  in  ADDR_WIDTH  source cache-line address, sampled on accepted start
- dst_base  in  ADDR_WIDTH  destination cache-line address, sampled on accepted start
- busy  out  1  job in progress
- done  out  1  job complete; held until the next accepted start
- rd_req_valid  out  1  read request valid
- rd_req_ready  in  1  read channel accepts request
- rd_req_addr  out  ADDR_WIDTH  read line address
- in_fifo_pop  in  1  AFU input FIFO read strobe; returns one credit
- out_fifo_empty  in  1  AFU output FIFO empty
- out_fifo_re  out  1  AFU output FIFO read; data valid the following cycle
- wr_almost_full  in  1  write channel cannot guarantee a free slot
- wr_req_valid  out  1  write request valid; always accepted
- wr_req_addr  out  ADDR_WIDTH  write line address
- wr_ack  in  1  one write completed
- rd_count  out  LEN_WIDTH  reads issued
- wr_count  out  LEN_WIDTH  write acks received

Behaviour:
- Reset values: all outputs 0. Internal state: FSM in IDLE, credits = 2**BUFF_DEPTH_BITS, all counters 0. Reset asserted mid-job aborts immediately to this state; in-flight responses are not tracked after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start=1:
  - latch length and both bases.
  - clear rd_count, wr_count, the internal pop count and the write index.
  - clear done.
  - go to RUN if length != 0; otherwise go to DONE with done=1 on the next cycle.
- start while in RUN is ignored.
- RUN, read side:
  - rd_req_valid = (rd_count < length) && (credits != 0), combinational from registers.
  - rd_req_addr = src_base + rd_count, modulo 2**ADDR_WIDTH.
  - Handshake when rd_req_valid && rd_req_ready: rd_count+1, credits-1.
  - valid must not drop without a handshake unless reset occurs; credits never decrease except on a handshake.
- Credits: credits+1 on in_fifo_pop. A simultaneous handshake and pop leaves credits unchanged. Credits saturate at 2**BUFF_DEPTH_BITS; a pop beyond that is an error and is ignored.
- RUN, write side:
  - out_fifo_re = !out_fifo_empty && !wr_almost_full && (pop count < length).
  - Each out_fifo_re increments the pop count.
  - Next cycle: wr_req_valid=1, wr_req_addr = dst_base + write index; write index +1.
  - Back-to-back pops give back-to-back writes, one per cycle.
- wr_ack increments wr_count in any state except IDLE.
- Completion: when wr_count reaches length, move RUN->DONE on the next edge. done=1 and busy=0 from that edge.
- busy = (state==RUN).
- Latency: read issue 0 cycles after credit/ready; write 1 cycle after pop.
- Simultaneous start and wr_ack in DONE: start wins and counters clear; the stale ack is dropped.

Test Plan:
- Length 1, rd_req_ready=1, instant FIFO loopback → one read at src_base; one pop; one write at dst_base one cycle after pop; wr_ack → done=1, rd_count=wr_count=1.
- Length 20, BUFF_DEPTH_BITS=3, in_fifo_pop never asserted → exactly 8 reads issued, then rd_req_valid=0. Assert one pop → exactly one more read.
- rd_req_ready low for 5 cycles while valid → rd_req_valid and rd_req_addr held stable; rd_count unchanged.
- Length 10, out_fifo_empty=0, wr_almost_full toggles every cycle → 10 pops total, none while almost-full; write addresses dst_base..dst_base+9 in order.
- ctx_length=0 on start → done=1 next cycle; no read or write requests.
- Reset asserted after 4 of 12 lines → all outputs 0 immediately. A fresh start with length 3 then completes normally with rd_count=wr_count=3.
